mips_processor: RTL and testbench
=================================

Name: mips_processor

Overview:
- Single-cycle 32-bit MIPS subset core, self-contained: PC, instruction ROM, 32x32 register file, ALU, barrel shifter, data RAM, main and ALU control.
- One instruction completes per rising clock edge.
- Three 32-bit observation buses expose internal datapath values for top-level debug and testbench monitoring.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in 32-bit words; index is PC[7:2].
- DMEM_WORDS, 64, data RAM depth in 32-bit words; index is address[7:2].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset; 0 = in reset.
- aluresout  output  32  combinational ALU result of the current instruction.
- shift_resultout  output  32  combinational shifter result, reg[rt] shifted by shamt.
- GP_DATA_INout  output  32  combinational register-file write-data mux output.

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=0, all 32 registers=0, all data RAM words=0.
  - Outputs follow the instruction at PC 0 combinationally: aluresout=5, shift_resultout=0, GP_DATA_INout=5.
- ROM contents, fixed at elaboration; words 8 and above are 0x00000000 (executes as sll $0,$0,0 = nop):
  - 0: 0x20010005 addi $1,$0,5
  - 1: 0x20020003 addi $2,$0,3
  - 2: 0x00221820 add $3,$1,$2
  - 3: 0x00021080 sll $2,$2,2
  - 4: 0xAC010014 sw $1,20($0)
  - 5: 0x8C030014 lw $3,20($0)
  - 6: 0x20010001 addi $1,$0,1
  - 7: 0x08000000 j 0
- Supported instructions; any other opcode or funct is a nop (no register or memory write, PC+4):
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00, srl 0x02.
  - I-type: addi 0x08 (sign-extended immediate), lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02.
- ALU:
  - Operand A=reg[rs]; operand B=reg[rt] (R-type/beq) or sign-extended imm16 (addi/lw/sw).
  - Arithmetic wraps modulo 2^32; no overflow trap. slt is a signed compare giving 1 or 0.
  - For sll/srl the ALU performs ADD; aluresout is still driven, value unused.
- Shifter: always computes reg[rt] shifted by instr[10:6]; logical left for sll, logical right for srl, left otherwise.
- Write-back:
  - GP_DATA_INout = memory read data for lw; shifter result for sll/srl; ALU result otherwise.
  - Destination is rd for R-type, rt for addi/lw. Written on the rising edge only when RegWrite=1.
  - Writes to $0 are ignored; $0 always reads 0.
- Register file: reads are combinational. A read of a register being written in the same cycle returns the old value.
- Data RAM: combinational read; sw writes reg[rt] to word address ALU[7:2] on the rising edge; the low 2 address bits are ignored.
- Next PC: j gives {PC+4[31:28], target26, 2'b00}; beq taken when reg[rs]==reg[rt] gives PC+4+(sext(imm)<<2); otherwise PC+4. PC wraps modulo ROM size.
- Reset asserted mid-program clears PC, registers and RAM immediately; execution restarts from word 0 after release.

Test Plan:
- Hold rst=0 for 10 ns, check aluresout=5, GP_DATA_INout=5 -> release rst; on the 1st edge $1=5.
- Run cycles 1-3 after reset: GP_DATA_INout sequence 3, 8, 12; shift_resultout=12 during the sll; final $2=12, $3=8.
- Cycle 4 (sw): aluresout=20, no register change, RAM word 5 = 5. Cycle 5 (lw): GP_DATA_INout=5, $3=5.
- Cycle 6: $1=1. Cycle 7 (j 0): PC returns to 0. Second loop pass reproduces $1=5, $2=3, $3=8 at cycle 10.
- Run 20 cycles -> $0 stays 0 throughout and all outputs are free of X.
- Assert rst low at cycle 5 for one cycle -> PC=0, $1-$3=0, RAM word 5=0; the program then re-executes correctly from word 0.

Source files
------------

// File: rtl/mips_processor.sv
// Single-cycle MIPS subset core: PC, fixed ROM, regfile, ALU,
// shifter, data RAM and control. One instruction per clock.
module mips_processor #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] aluresout,
  output logic [31:0] shift_resultout,
  output logic [31:0] GP_DATA_INout
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] rf [32];
  logic [31:0] dmem [DMEM_WORDS];

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] imm_sext;

  logic        reg_write;
  logic        reg_dst;
  logic        alu_src;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        jump;
  logic        shift_op;
  logic        shift_right;
  alu_op_e     alu_op;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic [31:0] shift_res;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;

  // Fixed program ROM; unlisted words are nop
  always_comb begin
    instr = 32'h0000_0000;
    case (int'(pc[IAW+1:2]))
      0: instr = 32'h2001_0005;
      1: instr = 32'h2002_0003;
      2: instr = 32'h0022_1820;
      3: instr = 32'h0002_1080;
      4: instr = 32'hAC01_0014;
      5: instr = 32'h8C03_0014;
      6: instr = 32'h2001_0001;
      7: instr = 32'h0800_0000;
      default: instr = 32'h0000_0000;
    endcase
  end

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};

  // Main and ALU control decode; unknown encodings become nops
  always_comb begin
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    shift_op    = 1'b0;
    shift_right = 1'b0;
    alu_op      = ALU_ADD;
    unique case (1'b1)
      (op == 6'h00): begin
        reg_dst = 1'b1;
        unique case (1'b1)
          (funct == 6'h20): begin
            reg_write = 1'b1;
          end
          (funct == 6'h22): begin
            reg_write = 1'b1;
            alu_op    = ALU_SUB;
          end
          (funct == 6'h24): begin
            reg_write = 1'b1;
            alu_op    = ALU_AND;
          end
          (funct == 6'h25): begin
            reg_write = 1'b1;
            alu_op    = ALU_OR;
          end
          (funct == 6'h2A): begin
            reg_write = 1'b1;
            alu_op    = ALU_SLT;
          end
          (funct == 6'h00): begin
            reg_write = 1'b1;
            shift_op  = 1'b1;
          end
          (funct == 6'h02): begin
            reg_write   = 1'b1;
            shift_op    = 1'b1;
            shift_right = 1'b1;
          end
          default: ;
        endcase
      end
      (op == 6'h08): begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      (op == 6'h23): begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        mem_read  = 1'b1;
      end
      (op == 6'h2B): begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      (op == 6'h04): begin
        branch = 1'b1;
        alu_op = ALU_SUB;
      end
      (op == 6'h02): begin
        jump = 1'b1;
      end
      default: ;
    endcase
  end

  assign rs_val = rf[rs];
  assign rt_val = rf[rt];
  assign alu_b  = alu_src ? imm_sext : rt_val;

  // ALU; wraps modulo 2^32, slt is signed
  always_comb begin
    alu_res = rs_val + alu_b;
    unique case (alu_op)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_SLT: alu_res = {31'b0, $signed(rs_val) < $signed(alu_b)};
      default: alu_res = rs_val + alu_b;
    endcase
  end

  assign shift_res = shift_right ? (rt_val >> shamt) : (rt_val << shamt);
  assign mem_rdata = dmem[alu_res[DAW+1:2]];

  assign wb_addr = reg_dst ? rd : rt;
  assign wb_data = mem_read ? mem_rdata :
                   shift_op ? shift_res : alu_res;

  assign pc_plus4 = pc + 32'd4;

  // Next-PC select: jump, taken branch, or fall-through
  always_comb begin
    pc_next = pc_plus4;
    if (jump)
      pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && (rs_val == rt_val))
      pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
  end

  // Program counter, wrapped to the ROM span
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else      pc <= pc_next & PC_MASK;
  end

  // Register file write port; $0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (reg_write && (wb_addr != 5'd0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Data RAM write port, word addressed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
    end else if (mem_write) begin
      dmem[alu_res[DAW+1:2]] <= rt_val;
    end
  end

  assign aluresout       = alu_res;
  assign shift_resultout = shift_res;
  assign GP_DATA_INout   = wb_data;

endmodule

// File: tb/tb_mips_processor.sv
// Testbench for mips_processor: fixed program checks plus
// random reset pulses against an instruction-level model.
module tb_mips_processor;

  logic        clk;
  logic        rst;
  logic [31:0] aluresout;
  logic [31:0] shift_resultout;
  logic [31:0] GP_DATA_INout;

  int checks = 0;
  int errors = 0;

  mips_processor dut (
    .clk             (clk),
    .rst             (rst),
    .aluresout       (aluresout),
    .shift_resultout (shift_resultout),
    .GP_DATA_INout   (GP_DATA_INout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level reference model
  bit [31:0] m_pc;
  bit [31:0] m_rf [32];
  bit [31:0] m_mem [64];

  function automatic bit [31:0] rom_word(input bit [31:0] pc);
    bit [31:0] w;
    case ((pc / 4) % 64)
      0: w = 32'h2001_0005;
      1: w = 32'h2002_0003;
      2: w = 32'h0022_1820;
      3: w = 32'h0002_1080;
      4: w = 32'hAC01_0014;
      5: w = 32'h8C03_0014;
      6: w = 32'h2001_0001;
      7: w = 32'h0800_0000;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    for (int i = 0; i < 64; i++) m_mem[i] = 0;
  endtask

  // Expected outputs and side effects of the instruction at m_pc
  task automatic model_eval(
    output bit [31:0] e_alu, output bit [31:0] e_sh,
    output bit [31:0] e_gp, output bit alu_ok, output bit gp_ok,
    output bit we, output int wa, output bit sw_en,
    output int sw_idx, output bit [31:0] sw_data,
    output bit [31:0] npc);
    bit [31:0] ins, a, b, imm, pc4;
    int op, rs, rt, rd, sh, fn;
    ins = rom_word(m_pc);
    op  = int'(ins >> 26);
    rs  = int'((ins >> 21) % 32);
    rt  = int'((ins >> 16) % 32);
    rd  = int'((ins >> 11) % 32);
    sh  = int'((ins >> 6) % 32);
    fn  = int'(ins % 64);
    imm = ins % 65536;
    if (imm >= 32768) imm = imm - 65536;
    a   = m_rf[rs];
    b   = m_rf[rt];
    pc4 = m_pc + 4;
    e_sh = (op == 0 && fn == 2) ? (b >> sh) : (b << sh);
    e_alu = 0; e_gp = 0; alu_ok = 0; gp_ok = 0;
    we = 0; wa = 0; sw_en = 0; sw_idx = 0; sw_data = 0;
    npc = pc4;
    case (op)
      0: begin
        alu_ok = 1; gp_ok = 1; we = 1; wa = rd;
        case (fn)
          'h20: e_alu = a + b;
          'h22: e_alu = a - b;
          'h24: e_alu = a & b;
          'h25: e_alu = a | b;
          'h2A: e_alu = ($signed(a) < $signed(b)) ? 1 : 0;
          'h00, 'h02: e_alu = a + b;
          default: begin alu_ok = 0; gp_ok = 0; we = 0; end
        endcase
        e_gp = (fn == 0 || fn == 2) ? e_sh : e_alu;
      end
      'h08: begin
        e_alu = a + imm; e_gp = e_alu;
        alu_ok = 1; gp_ok = 1; we = 1; wa = rt;
      end
      'h23: begin
        e_alu = a + imm; e_gp = m_mem[(e_alu / 4) % 64];
        alu_ok = 1; gp_ok = 1; we = 1; wa = rt;
      end
      'h2B: begin
        e_alu = a + imm; e_gp = e_alu;
        alu_ok = 1; gp_ok = 1;
        sw_en = 1; sw_idx = int'((e_alu / 4) % 64); sw_data = b;
      end
      'h04: if (a == b) npc = pc4 + imm * 4;
      'h02: npc = (pc4 & 32'hF000_0000) | ((ins % (1 << 26)) * 4);
      default: ;
    endcase
    npc = npc % 256;
  endtask

  task automatic model_step();
    bit [31:0] e_alu, e_sh, e_gp, sw_data, npc;
    bit alu_ok, gp_ok, we, sw_en;
    int wa, sw_idx;
    model_eval(e_alu, e_sh, e_gp, alu_ok, gp_ok, we, wa,
               sw_en, sw_idx, sw_data, npc);
    if (we && wa != 0) m_rf[wa] = e_gp;
    if (sw_en) m_mem[sw_idx] = sw_data;
    m_pc = npc;
  endtask

  // One clock: model follows the DUT unless reset is held
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (aluresout !== 32'd5) begin
      errors++;
      $display("FAIL reset_alu: got %0d want 5", aluresout);
    end
    checks++;
    if (GP_DATA_INout !== 32'd5) begin
      errors++;
      $display("FAIL reset_gp: got %0d want 5", GP_DATA_INout);
    end
    checks++;
    if (shift_resultout !== 32'd0) begin
      errors++;
      $display("FAIL reset_shift: got %0d want 0", shift_resultout);
    end
    checks++;
    if (dut.pc !== 32'd0 || dut.rf[1] !== 32'd0 || dut.dmem[5] !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: pc=%0d r1=%0d m5=%0d want 0",
               dut.pc, dut.rf[1], dut.dmem[5]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (dut.rf[1] !== 32'd5) begin
      errors++;
      $display("FAIL first_addi: r1=%0d want 5", dut.rf[1]);
    end
  endtask

  task automatic test_program();
    checks++;
    if (GP_DATA_INout !== 32'd3) begin
      errors++;
      $display("FAIL c1_gp: got %0d want 3", GP_DATA_INout);
    end
    tick();
    checks++;
    if (GP_DATA_INout !== 32'd8) begin
      errors++;
      $display("FAIL c2_gp: got %0d want 8", GP_DATA_INout);
    end
    tick();
    checks++;
    if (GP_DATA_INout !== 32'd12 || shift_resultout !== 32'd12) begin
      errors++;
      $display("FAIL c3_sll: gp=%0d sh=%0d want 12 12",
               GP_DATA_INout, shift_resultout);
    end
    tick();
    checks++;
    if (dut.rf[2] !== 32'd12 || dut.rf[3] !== 32'd8) begin
      errors++;
      $display("FAIL c3_regs: r2=%0d r3=%0d want 12 8",
               dut.rf[2], dut.rf[3]);
    end
    checks++;
    if (aluresout !== 32'd20) begin
      errors++;
      $display("FAIL c4_sw_alu: got %0d want 20", aluresout);
    end
    tick();
    checks++;
    if (dut.dmem[5] !== 32'd5 || dut.rf[1] !== 32'd5 ||
        dut.rf[2] !== 32'd12 || dut.rf[3] !== 32'd8) begin
      errors++;
      $display("FAIL c4_sw: m5=%0d r1=%0d r2=%0d r3=%0d want 5 5 12 8",
               dut.dmem[5], dut.rf[1], dut.rf[2], dut.rf[3]);
    end
    checks++;
    if (GP_DATA_INout !== 32'd5) begin
      errors++;
      $display("FAIL c5_lw_gp: got %0d want 5", GP_DATA_INout);
    end
    tick();
    checks++;
    if (dut.rf[3] !== 32'd5) begin
      errors++;
      $display("FAIL c5_lw: r3=%0d want 5", dut.rf[3]);
    end
    tick();
    checks++;
    if (dut.rf[1] !== 32'd1) begin
      errors++;
      $display("FAIL c6_addi: r1=%0d want 1", dut.rf[1]);
    end
    tick();
    checks++;
    if (dut.pc !== 32'd0) begin
      errors++;
      $display("FAIL c7_jump: pc=%0d want 0", dut.pc);
    end
    repeat (3) tick();
    checks++;
    if (dut.rf[1] !== 32'd5 || dut.rf[2] !== 32'd3 || dut.rf[3] !== 32'd8) begin
      errors++;
      $display("FAIL c10_loop: r1=%0d r2=%0d r3=%0d want 5 3 8",
               dut.rf[1], dut.rf[2], dut.rf[3]);
    end
  endtask

  task automatic test_run20();
    bit [31:0] e_alu, e_sh, e_gp, sw_data, npc;
    bit alu_ok, gp_ok, we, sw_en;
    int wa, sw_idx;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      model_eval(e_alu, e_sh, e_gp, alu_ok, gp_ok, we, wa,
                 sw_en, sw_idx, sw_data, npc);
      checks++;
      if ($isunknown({aluresout, shift_resultout, GP_DATA_INout}) ||
          dut.rf[0] !== 32'd0) begin
        errors++;
        $display("FAIL run20_x_r0: cyc=%0d r0=%0h", c, dut.rf[0]);
      end
      checks++;
      if (shift_resultout !== e_sh ||
          (alu_ok && aluresout !== e_alu) ||
          (gp_ok && GP_DATA_INout !== e_gp)) begin
        errors++;
        $display("FAIL run20_out: cyc=%0d alu=%0h/%0h sh=%0h/%0h gp=%0h/%0h",
                 c, aluresout, e_alu, shift_resultout, e_sh,
                 GP_DATA_INout, e_gp);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (5) tick();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut.pc !== 32'd0 || dut.rf[1] !== 32'd0 || dut.rf[2] !== 32'd0 ||
        dut.rf[3] !== 32'd0 || dut.dmem[5] !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: pc=%0d r1=%0d r2=%0d r3=%0d m5=%0d want 0",
               dut.pc, dut.rf[1], dut.rf[2], dut.rf[3], dut.dmem[5]);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    checks++;
    if (dut.pc !== m_pc || dut.rf[1] !== m_rf[1] || dut.rf[2] !== m_rf[2] ||
        dut.rf[3] !== m_rf[3] || dut.dmem[5] !== m_mem[5]) begin
      errors++;
      $display("FAIL mid_restart: pc=%0d/%0d r1=%0d/%0d r2=%0d/%0d r3=%0d/%0d m5=%0d/%0d",
               dut.pc, m_pc, dut.rf[1], m_rf[1], dut.rf[2], m_rf[2],
               dut.rf[3], m_rf[3], dut.dmem[5], m_mem[5]);
    end
  endtask

  task automatic test_random_reset();
    bit [31:0] e_alu, e_sh, e_gp, sw_data, npc;
    bit alu_ok, gp_ok, we, sw_en;
    int wa, sw_idx;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      if (rst && $urandom_range(0, 19) == 0) begin
        rst = 1'b0;
        model_reset();
      end else if (!rst && $urandom_range(0, 1) == 0) begin
        rst = 1'b1;
      end
      #1;
      model_eval(e_alu, e_sh, e_gp, alu_ok, gp_ok, we, wa,
                 sw_en, sw_idx, sw_data, npc);
      checks++;
      if (dut.pc !== m_pc || dut.rf[0] !== 32'd0 ||
          dut.rf[1] !== m_rf[1] || dut.rf[2] !== m_rf[2] ||
          dut.rf[3] !== m_rf[3] || dut.dmem[5] !== m_mem[5]) begin
        errors++;
        $display("FAIL rand_state: cyc=%0d pc=%0d/%0d r1=%0d/%0d r2=%0d/%0d r3=%0d/%0d m5=%0d/%0d",
                 c, dut.pc, m_pc, dut.rf[1], m_rf[1], dut.rf[2], m_rf[2],
                 dut.rf[3], m_rf[3], dut.dmem[5], m_mem[5]);
      end
      checks++;
      if (shift_resultout !== e_sh ||
          (alu_ok && aluresout !== e_alu) ||
          (gp_ok && GP_DATA_INout !== e_gp)) begin
        errors++;
        $display("FAIL rand_out: cyc=%0d alu=%0h/%0h sh=%0h/%0h gp=%0h/%0h",
                 c, aluresout, e_alu, shift_resultout, e_sh,
                 GP_DATA_INout, e_gp);
      end
      tick();
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_program();
    test_run20();
    test_mid_reset();
    test_random_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
